// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter and sequencer that shares one AES core between two job sources.
// Holds core inputs stable while it runs and returns the ciphertext, or a watchdog abort.
module aes_core_arbiter #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req0_key,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [DATA_W-1:0] req1_key,
    output logic              core_en,
    output logic [DATA_W-1:0] core_data_in,
    output logic [DATA_W-1:0] core_key_in,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_data_out_valid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_timeout,
    output logic              busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              tmo_q, tmo_d;

    logic idle;
    logic any_req;
    logic grant1;

    assign idle    = (state_q == StIdle);
    assign any_req = req0_valid | req1_valid;
    // On contention the requester not granted last wins.
    assign grant1  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    assign req0_ready = idle & any_req & ~grant1;
    assign req1_ready = idle & grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        data_d       = data_q;
        key_d        = key_q;
        res_d        = res_q;
        tmo_d        = tmo_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d      = StRun;
                    last_grant_d = grant1;
                    id_d         = grant1;
                    data_d       = grant1 ? req1_data : req0_data;
                    key_d        = grant1 ? req1_key : req0_key;
                    cnt_d        = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 8'd1;
                // Core valid takes precedence over the watchdog in the same cycle.
                if (core_data_out_valid) begin
                    res_d   = core_data_out;
                    tmo_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
            key_q        <= '0;
            res_q        <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            data_q       <= data_d;
            key_q        <= key_d;
            res_q        <= res_d;
            tmo_q        <= tmo_d;
        end
    end

    assign core_en      = (state_q == StRun);
    assign core_data_in = data_q;
    assign core_key_in  = key_q;
    assign resp_valid   = (state_q == StResp);
    assign resp_id      = id_q;
    assign resp_data    = res_q;
    assign resp_timeout = tmo_q;
    assign busy         = ~idle;

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Two-requester round-robin arbiter and sequencer for one shared `AES_top` encryption core. It accepts 128-bit plaintext/key jobs over valid/ready handshakes and drives the core's enable, data and key inputs stable for the whole operation. It waits for `AES_data_out_valid` (or a watchdog timeout) and returns the result with the requester ID over a valid/ready response channel. It sits between the system-side job sources and the `AES_top` instance.

## Interface
Parameters:
- `DATA_W`, 128, width of data, key and result buses.
- `TIMEOUT`, 64, maximum RUN cycles to wait for core valid before aborting; legal range 2..255.

Ports:
- `AES_clk` in 1: single clock, rising edge.
- `AES_rst_n` in 1: reset, asynchronous assert, active-low.
- `req0_valid` in 1; `req0_ready` out 1; `req0_data` in DATA_W; `req0_key` in DATA_W: requester 0 job channel.
- `req1_valid` in 1; `req1_ready` out 1; `req1_data` in DATA_W; `req1_key` in DATA_W: requester 1 job channel.
- `core_en` out 1: connects to `AES_top.AES_en`.
- `core_data_in` out DATA_W: connects to `AES_top.AES_data_in`.
- `core_key_in` out DATA_W: connects to `AES_top.AES_key_in`.
- `core_data_out` in DATA_W: from `AES_top.AES_data_out`.
- `core_data_out_valid` in 1: from `AES_top.AES_data_out_valid`.
- `resp_valid` out 1; `resp_ready` in 1: response handshake.
- `resp_id` out 1: 0 = requester 0, 1 = requester 1.
- `resp_data` out DATA_W: ciphertext, or 0 on timeout.
- `resp_timeout` out 1: response produced by the watchdog.
- `busy` out 1: high in RUN and RESP.

## Operation
FSM states: IDLE, RUN, RESP. Reset state is IDLE.
- **IDLE**
  - Arbitration: if only one `reqN_valid` is high, that requester wins. If both are high, the winner is the requester not granted last (`last_grant`, reset value 1, so requester 0 wins first).
  - `reqN_ready` is combinational and is asserted only for the winner, only in IDLE.
  - On handshake (valid & ready): capture data, key and ID into holding registers, update `last_grant`, clear the cycle counter, go to RUN.
- **RUN**
  - `core_en` = 1. `core_data_in` and `core_key_in` = holding registers, stable for the whole state.
  - The 8-bit counter increments every cycle.
  - If `core_data_out_valid` = 1: capture `core_data_out` into `resp_data`, clear `resp_timeout`, go to RESP.
  - Else if counter = TIMEOUT-1: set `resp_data` = 0 and `resp_timeout` = 1, go to RESP.
  - Core valid wins over timeout in the same cycle.
- **RESP**
  - `core_en` = 0. `resp_valid` = 1. `resp_id`, `resp_data` and `resp_timeout` are held stable.
  - On `resp_valid & resp_ready`: go to IDLE.
  - No new job is accepted in RESP.
- `core_data_out_valid` outside RUN is ignored.
- `core_en` is low for at least 2 cycles between jobs (one RESP cycle plus one IDLE cycle).
- `core_data_in` and `core_key_in` hold their last value outside RUN; they are 0 after reset.

## Timing
- Reset values: all outputs 0 (`req0_ready`/`req1_ready` follow the IDLE rule after release). `last_grant` = 1, counter = 0.
- Reset is asynchronous and may be asserted in any state. It aborts the job with no response and drops `core_en` immediately. Only `AES_rst_n` clears state.
- Latency:
  - Handshake at edge N → `core_en` high from edge N.
  - Core valid sampled at edge M → `resp_valid` high from edge M.
  - Earliest next `reqN_ready`: the cycle after the response handshake.
- Timeout: `resp_valid` rises TIMEOUT cycles after `core_en` rises.
- A requester dropping `reqN_valid` without a handshake is legal; arbitration is re-evaluated every IDLE cycle.

## Test plan
- **FIPS-197 single job.** Req0 with key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff → `resp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `resp_id` = 0, `resp_timeout` = 0. `core_en` stays high and inputs stay stable until core valid.
- **Simultaneous requests.** Both requesters valid in the same cycle after reset → req0 served first, then req1. Jobs submitted continuously alternate 0,1,0,1 with no starvation.
- **Watchdog.** Stub core that never asserts valid, TIMEOUT = 8 → `resp_valid` rises 8 cycles after `core_en`, with `resp_timeout` = 1 and `resp_data` = 0.
- **Response backpressure.** `resp_ready` held low 5 cycles with req1 pending → `resp_*` stable and `core_en` = 0 throughout. `req1_ready` rises only the cycle after the handshake.
- **Reset mid-RUN.** `AES_rst_n` pulsed low mid-job → `core_en` drops asynchronously, no response is produced, and the next job runs correctly with req0 priority restored.
- **Valid/timeout collision.** Core valid in the same cycle as counter = TIMEOUT-1 → ciphertext returned with `resp_timeout` = 0.
